// File: rtl/rgb_fade_ramp.sv
// Linear per-channel fade from the current RGB duty to the latest target.
// One done pulse once all three channels have reached their targets.
module rgb_fade_ramp #(
  parameter int TICK_DIV = 48000,
  parameter int STEP     = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  input  logic       i_valid,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] tgt_r, tgt_g, tgt_b;
  logic [7:0] tgt_r_n, tgt_g_n, tgt_b_n;
  logic [7:0] cur_r_n, cur_g_n, cur_b_n;
  logic done_n;
  logic tick;

  // 9-bit arithmetic so a large step clamps at the target, never wraps
  function automatic logic [7:0] ramp(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    logic [8:0] c;
    logic [8:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (c < t)
      return (t - c <= STEP9) ? tgt : 8'(c + STEP9);
    else if (c > t)
      return (c - t <= STEP9) ? tgt : 8'(c - STEP9);
    return cur;
  endfunction

  assign tick = (state == FADE) && (cnt == CNT_MAX);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tgt_r_n = tgt_r;
    tgt_g_n = tgt_g;
    tgt_b_n = tgt_b;
    cur_r_n = o_red;
    cur_g_n = o_green;
    cur_b_n = o_blue;
    done_n  = 1'b0;
    if (i_valid) begin
      tgt_r_n = i_red;
      tgt_g_n = i_green;
      tgt_b_n = i_blue;
      cnt_n   = '0;
      if (i_red == o_red && i_green == o_green &&
          i_blue == o_blue) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = FADE;
      end
    end else if (state == FADE) begin
      if (tick) begin
        cnt_n   = '0;
        cur_r_n = ramp(o_red, tgt_r);
        cur_g_n = ramp(o_green, tgt_g);
        cur_b_n = ramp(o_blue, tgt_b);
        if (cur_r_n == tgt_r && cur_g_n == tgt_g &&
            cur_b_n == tgt_b) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tgt_r   <= '0;
      tgt_g   <= '0;
      tgt_b   <= '0;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tgt_r   <= tgt_r_n;
      tgt_g   <= tgt_g_n;
      tgt_b   <= tgt_b_n;
      o_red   <= cur_r_n;
      o_green <= cur_g_n;
      o_blue  <= cur_b_n;
      o_done  <= done_n;
    end
  end

  assign o_busy = (state == FADE);

endmodule

// File: tb/tb_rgb_fade_ramp.sv
// Bench for rgb_fade_ramp: three parameterisations share one stimulus
// stream and are checked every cycle against an arithmetic fade model.
module tb_rgb_fade_ramp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [7:0] ir = '0;
  logic [7:0] ig = '0;
  logic [7:0] ib = '0;

  logic [2:0][7:0] o_r;
  logic [2:0][7:0] o_g;
  logic [2:0][7:0] o_b;
  logic [2:0] o_bz;
  logic [2:0] o_dn;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rgb_fade_ramp #(.TICK_DIV(4), .STEP(1)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_red(ir), .i_green(ig), .i_blue(ib), .i_valid(vld),
    .o_red(o_r[0]), .o_green(o_g[0]), .o_blue(o_b[0]),
    .o_busy(o_bz[0]), .o_done(o_dn[0])
  );

  rgb_fade_ramp #(.TICK_DIV(4), .STEP(100)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_red(ir), .i_green(ig), .i_blue(ib), .i_valid(vld),
    .o_red(o_r[1]), .o_green(o_g[1]), .o_blue(o_b[1]),
    .o_busy(o_bz[1]), .o_done(o_dn[1])
  );

  rgb_fade_ramp #(.TICK_DIV(1), .STEP(1)) dut_c (
    .i_clk(clk), .i_rst(rst),
    .i_red(ir), .i_green(ig), .i_blue(ib), .i_valid(vld),
    .o_red(o_r[2]), .o_green(o_g[2]), .o_blue(o_b[2]),
    .o_busy(o_bz[2]), .o_done(o_dn[2])
  );

  // reference model state, one slot per instance
  int tdv[3] = '{4, 4, 1};
  int stv[3] = '{1, 100, 1};
  int m_cur[3][3];
  int m_tgt[3][3];
  int m_age[3];
  bit m_fade[3];
  bit m_done[3];

  function automatic int stp(int c, int t, int s);
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  function automatic bit at_tgt(int i);
    return m_cur[i][0] == m_tgt[i][0] && m_cur[i][1] == m_tgt[i][1] &&
           m_cur[i][2] == m_tgt[i][2];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (rst) begin
        for (int c = 0; c < 3; c++) begin
          m_cur[i][c] = 0;
          m_tgt[i][c] = 0;
        end
        m_fade[i] = 1'b0;
        m_age[i]  = 0;
      end else if (vld) begin
        m_tgt[i][0] = int'(ir);
        m_tgt[i][1] = int'(ig);
        m_tgt[i][2] = int'(ib);
        m_age[i] = 0;
        m_fade[i] = !at_tgt(i);
        m_done[i] = at_tgt(i);
      end else if (m_fade[i]) begin
        m_age[i]++;
        if (m_age[i] % tdv[i] == 0) begin
          for (int c = 0; c < 3; c++)
            m_cur[i][c] = stp(m_cur[i][c], m_tgt[i][c], stv[i]);
          if (at_tgt(i)) begin
            m_fade[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %07h want %07h", nm, act, exp);
    end
  endtask

  function automatic int pack(logic [7:0] r, logic [7:0] g, logic [7:0] b,
                              logic bz, logic dn);
    return int'({r, g, b, bz, dn});
  endfunction

  task automatic cyc(bit r, bit v, logic [7:0] a, logic [7:0] b,
                     logic [7:0] c);
    @(negedge clk);
    rst = r;
    vld = v;
    ir  = a;
    ig  = b;
    ib  = c;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("model%0d", i),
          pack(o_r[i], o_g[i], o_b[i], o_bz[i], o_dn[i]),
          pack(8'(m_cur[i][0]), 8'(m_cur[i][1]), 8'(m_cur[i][2]),
               m_fade[i], m_done[i]));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic chk_inst(string nm, int i, logic [7:0] r, logic [7:0] g,
                          logic [7:0] b, logic bz, logic dn);
    chk(nm, pack(o_r[i], o_g[i], o_b[i], o_bz[i], o_dn[i]),
        pack(r, g, b, bz, dn));
  endtask

  typedef struct {
    bit rst;
    bit vld;
    logic [7:0] r, g, b;
    int n;
    logic [7:0] er, eg, eb;
    bit ebusy, edone;
  } vec_t;

  vec_t vt[13];

  initial begin
    // expected values for instance a (TICK_DIV=4, STEP=1)
    vt[0]  = '{1, 1, 8'h09, 8'h09, 8'h09, 1, 8'h00, 8'h00, 8'h00, 0, 0};
    vt[1]  = '{1, 1, 8'h09, 8'h09, 8'h09, 1, 8'h00, 8'h00, 8'h00, 0, 0};
    vt[2]  = '{1, 1, 8'h09, 8'h09, 8'h09, 1, 8'h00, 8'h00, 8'h00, 0, 0};
    vt[3]  = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0, 0};
    vt[4]  = '{0, 1, 8'h10, 8'h00, 8'h00, 4, 8'h00, 8'h00, 8'h00, 1, 0};
    vt[5]  = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 1, 0};
    vt[6]  = '{0, 0, 8'h00, 8'h00, 8'h00, 59, 8'h0f, 8'h00, 8'h00, 1, 0};
    vt[7]  = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 1};
    vt[8]  = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 0};
    vt[9]  = '{0, 1, 8'h05, 8'h06, 8'h07, 44, 8'h06, 8'h06, 8'h07, 1, 0};
    vt[10] = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h05, 8'h06, 8'h07, 0, 1};
    vt[11] = '{0, 1, 8'h05, 8'h06, 8'h07, 1, 8'h05, 8'h06, 8'h07, 0, 1};
    vt[12] = '{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h05, 8'h06, 8'h07, 0, 0};

    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) begin
        m_cur[i][c] = 0;
        m_tgt[i][c] = 0;
      end
      m_age[i] = 0;
      m_fade[i] = 1'b0;
      m_done[i] = 1'b0;
    end

    for (int v = 0; v < 13; v++) begin
      cyc(vt[v].rst, vt[v].vld, vt[v].r, vt[v].g, vt[v].b);
      idle(vt[v].n - 1);
      chk_inst($sformatf("vec%0d", v), 0, vt[v].er, vt[v].eg, vt[v].eb,
               vt[v].ebusy, vt[v].edone);
    end

    // big step clamps exactly at the target
    cyc(1, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 8'd200, 8'd50, 8'd0);
    idle(8);
    chk_inst("step100_pre", 1, 8'd200, 8'd50, 8'd0, 0, 1);
    cyc(0, 1, 8'd255, 8'd0, 8'd0);
    idle(3);
    chk_inst("step100_mid", 1, 8'd200, 8'd50, 8'd0, 1, 0);
    idle(1);
    chk_inst("step100_end", 1, 8'd255, 8'd0, 8'd0, 0, 1);

    // retarget mid-fade
    cyc(1, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 8'h40, 8'h00, 8'h00);
    idle(32);
    chk_inst("retgt_at8", 0, 8'h08, 8'h00, 8'h00, 1, 0);
    cyc(0, 1, 8'h00, 8'h00, 8'h00);
    chk_inst("retgt_latch", 0, 8'h08, 8'h00, 8'h00, 1, 0);
    idle(31);
    chk_inst("retgt_down", 0, 8'h01, 8'h00, 8'h00, 1, 0);
    idle(1);
    chk_inst("retgt_done", 0, 8'h00, 8'h00, 8'h00, 0, 1);

    // valid on a tick edge drops that step; then reset mid-fade
    cyc(1, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 8'h20, 8'h00, 8'h00);
    idle(3);
    cyc(0, 1, 8'h20, 8'h00, 8'h00);
    chk_inst("coinc_drop", 0, 8'h00, 8'h00, 8'h00, 1, 0);
    idle(3);
    chk_inst("coinc_wait", 0, 8'h00, 8'h00, 8'h00, 1, 0);
    idle(1);
    chk_inst("coinc_step", 0, 8'h01, 8'h00, 8'h00, 1, 0);
    idle(5);
    cyc(1, 0, 8'h00, 8'h00, 8'h00);
    chk_inst("rst_mid", 0, 8'h00, 8'h00, 8'h00, 0, 0);
    idle(1);
    chk_inst("rst_after", 0, 8'h00, 8'h00, 8'h00, 0, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        cyc(1, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
            8'($urandom));
      end else if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 5) == 0)
          cyc(0, 1, 8'(m_cur[0][0]), 8'(m_cur[0][1]), 8'(m_cur[0][2]));
        else
          cyc(0, 1, 8'($urandom_range(0, 40)), 8'($urandom),
              8'($urandom_range(0, 40)));
      end else begin
        idle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
